// File: rtl/addr8u_share_ctrl_pkg.sv
// Shared types and sizing helpers for the shared 8-bit adder controller.
package addr8u_ctrl_pkg;

    localparam int OPW  = 8;
    localparam int SUMW = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN1 = 3'd1,
        RUN2 = 3'd2,
        CMP  = 3'd3,
        RESP = 3'd4
    } state_e;

    // Requester index width: clog2(n), at least 1 bit, capped to the 3-bit rsp_id port.
    function automatic int id_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) w = 1;
        if (w > 3) w = 3;
        return w;
    endfunction

endpackage

// File: rtl/addr8u_share_ctrl_arb.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, with wrap.
module rr_arbiter
    import addr8u_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    localparam int OW = IDW + 1;

    logic [NREQ-1:0][OW-1:0] w_off;

    // Distance of each requester from the pointer, modulo NREQ.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) >= {1'b0, i_ptr})
                w_off[i] = OW'(i) - {1'b0, i_ptr};
            else
                w_off[i] = OW'(i) + OW'(NREQ) - {1'b0, i_ptr};
        end
    end

    // Scan distances from farthest to nearest so the nearest valid one wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_req[i] && w_off[i] == OW'(k)) begin
                    o_gnt    = '0;
                    o_gnt[i] = 1'b1;
                    o_idx    = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/addr8u_share_ctrl.sv
// Shares one external combinational 8-bit adder among NREQ requesters; each job is
// evaluated as A+B and B+A, retried on mismatch and flagged if it never agrees.
module addr8u_share_ctrl
    import addr8u_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_a,
    input  logic [NREQ*OPW-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [SUMW-1:0]       rsp_sum,
    output logic                  rsp_err,
    output logic [OPW-1:0]        add_a,
    output logic [OPW-1:0]        add_b,
    input  logic [SUMW-1:0]       add_sum,
    output logic [CNT_W-1:0]      fault_cnt
);

    localparam int IDW = id_w(NREQ);
    localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_add_a;
    logic [OPW-1:0]  r_add_b;
    logic [SUMW-1:0] r_sum1;
    logic [SUMW-1:0] r_sum2;
    logic [RTW-1:0]  r_retry;
    logic            r_err;
    logic [CNT_W-1:0] r_fault;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic [OPW-1:0]  w_sel_a;
    logic [OPW-1:0]  w_sel_b;
    logic            w_accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*OPW +: OPW];
                w_sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is held.
    assign w_accept  = (r_state == IDLE) && (|req_valid);
    assign req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_sum1  <= '0;
            r_sum2  <= '0;
            r_retry <= '0;
            r_err   <= 1'b0;
            r_fault <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a     <= w_sel_a;
                    r_b     <= w_sel_b;
                    r_id    <= w_idx;
                    r_retry <= '0;
                    r_add_a <= w_sel_a;
                    r_add_b <= w_sel_b;
                    r_state <= RUN1;
                end
                RUN1: begin
                    r_sum1  <= add_sum;
                    r_add_a <= r_b;
                    r_add_b <= r_a;
                    r_state <= RUN2;
                end
                RUN2: begin
                    r_sum2  <= add_sum;
                    r_state <= CMP;
                end
                CMP: begin
                    if (r_sum1 == r_sum2) begin
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else begin
                        if (r_fault != '1) r_fault <= r_fault + CNT_W'(1);
                        if (r_retry < RTW'(MAX_RETRY)) begin
                            r_retry <= r_retry + RTW'(1);
                            r_add_a <= r_a;
                            r_add_b <= r_b;
                            r_state <= RUN1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                RESP: if (rsp_ready) begin
                    r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // On an unresolved mismatch r_sum1 still holds the A+B pass, so it is always the answer.
    assign rsp_valid = (r_state == RESP);
    assign rsp_sum   = r_sum1;
    assign rsp_err   = r_err;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign fault_cnt = r_fault;

    always_comb begin
        rsp_id = '0;
        rsp_id[IDW-1:0] = r_id;
    end

endmodule
